// File: rtl/mips_mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// op and state encodings, iteration count and operand helpers.
package mips_mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } mdu_state_e;

    localparam int          MDU_ITER     = 32;
    localparam logic [4:0]  MDU_CNT_LAST = 5'(MDU_ITER - 1);
    localparam logic [31:0] MDU_DIV0_LO  = 32'hFFFFFFFF;

    // 32'h80000000 maps to 2^31, which still fits as an unsigned magnitude.
    function automatic logic [31:0] mag32(
        input logic [31:0] v,
        input logic        is_signed
    );
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mdu_core.sv
// 64-bit datapath of the multiply/divide unit: shift-add multiply
// (LSB first) or restoring divide (MSB first), one step per cycle.
module mdu_core
    import mips_mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic        is_div,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic [63:0] acc
);

    logic [31:0] m;
    logic        div_mode;
    logic [32:0] mul_sum;
    logic [31:0] div_diff;
    logic        div_borrow;
    logic [63:0] acc_nx;

    // One iteration: add-and-shift for multiply, trial-subtract for divide
    always_comb begin
        mul_sum    = {1'b0, acc[63:32]} + {1'b0, m};
        div_borrow = acc[63:31] < {1'b0, m};
        div_diff   = acc[62:31] - m;
        acc_nx     = acc;
        if (div_mode) begin
            if (div_borrow) begin
                acc_nx = {acc[62:0], 1'b0};
            end else begin
                acc_nx = {div_diff, acc[30:0], 1'b1};
            end
        end else begin
            if (acc[0]) begin
                acc_nx = {mul_sum, acc[31:1]};
            end else begin
                acc_nx = {1'b0, acc[63:1]};
            end
        end
    end

    // Accumulator and multiplicand/divisor register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc      <= '0;
            m        <= '0;
            div_mode <= 1'b0;
        end else if (load) begin
            acc      <= {32'b0, x};
            m        <= y;
            div_mode <= is_div;
        end else if (step) begin
            acc <= acc_nx;
        end
    end

endmodule

// File: rtl/mdu.sv
// Iterative MIPS multiply/divide unit: control FSM, operand
// latching, sign fixup and the architectural HI/LO registers.
module mdu
    import mips_mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    mdu_state_e  state, state_nx;
    mdu_op_e     op_in, op_q;
    logic        sgn_in, div_in, sgn_q, div_q;
    logic        sa, sb, bz;
    logic [4:0]  cnt;
    logic        load, step, fix, mt_ok;
    logic        busy_nx, done_nx;
    logic [31:0] a_mag, b_mag, core_x, core_y;
    logic [63:0] acc, prod;
    logic [31:0] hi_fix, lo_fix;

    assign op_in  = mdu_op_e'(op);
    assign sgn_in = (op_in == MDU_MULT) || (op_in == MDU_DIV);
    assign div_in = (op_in == MDU_DIV) || (op_in == MDU_DIVU);
    assign sgn_q  = (op_q == MDU_MULT) || (op_q == MDU_DIV);
    assign div_q  = (op_q == MDU_DIV) || (op_q == MDU_DIVU);

    assign a_mag  = mag32(a, sgn_in);
    assign b_mag  = mag32(b, sgn_in);
    // Accumulator low half seeds with the multiplier or the dividend.
    assign core_x = div_in ? a_mag : b_mag;
    assign core_y = div_in ? b_mag : a_mag;

    mdu_core u_core (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .step   (step),
        .is_div (div_in),
        .x      (core_x),
        .y      (core_y),
        .acc    (acc)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (start) state_nx = S_RUN;
            S_RUN:   if (cnt == MDU_CNT_LAST) state_nx = S_FIX;
            S_FIX:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Per-state control strobes
    always_comb begin
        load    = (state == S_IDLE) && start;
        step    = (state == S_RUN);
        fix     = (state == S_FIX);
        mt_ok   = (state == S_IDLE) && !start;
        busy_nx = (state_nx != S_IDLE);
        done_nx = fix;
    end

    // Registered handshake outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_nx;
            done <= done_nx;
        end
    end

    // Latch op, operand signs and divide-by-zero; count iterations
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q <= MDU_MULT;
            sa   <= 1'b0;
            sb   <= 1'b0;
            bz   <= 1'b0;
            cnt  <= '0;
        end else if (load) begin
            op_q <= op_in;
            sa   <= a[31];
            sb   <= b[31];
            bz   <= (b == 32'd0);
            cnt  <= '0;
        end else if (step) begin
            cnt <= cnt + 5'd1;
        end
    end

    // Sign correction of the raw magnitude result.
    // For a zero divisor the remainder half already holds |a|, so the
    // dividend-sign rule returns a unchanged; only LO is overridden.
    always_comb begin
        prod   = acc;
        hi_fix = acc[63:32];
        lo_fix = acc[31:0];
        if (div_q) begin
            if (sgn_q && (sa ^ sb)) lo_fix = ~acc[31:0] + 32'd1;
            if (bz) lo_fix = MDU_DIV0_LO;
            if (sgn_q && sa) hi_fix = ~acc[63:32] + 32'd1;
        end else begin
            if (sgn_q && (sa ^ sb)) prod = ~acc + 64'd1;
            hi_fix = prod[63:32];
            lo_fix = prod[31:0];
        end
    end

    // HI/LO: result writeback wins; MTHI/MTLO only when idle without start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi <= '0;
            lo <= '0;
        end else if (fix) begin
            hi <= hi_fix;
            lo <= lo_fix;
        end else if (mt_ok) begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed cases, randomized ops
// against an arithmetic model, handshake and reset scenarios.
module tb_mdu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_fail = 0;

    mdu dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    // Architectural result of one operation, from plain arithmetic
    function automatic void model(
        input  logic [1:0]  o,
        input  logic [31:0] x,
        input  logic [31:0] y,
        output logic [31:0] eh,
        output logic [31:0] el
    );
        longint p;
        logic [63:0] u;
        int sx, sy;
        sx = x;
        sy = y;
        eh = '0;
        el = '0;
        if (o == 2'b00) begin
            p  = longint'(sx) * longint'(sy);
            eh = p[63:32];
            el = p[31:0];
        end else if (o == 2'b01) begin
            u  = {32'b0, x} * {32'b0, y};
            eh = u[63:32];
            el = u[31:0];
        end else if (y == 32'd0) begin
            eh = x;
            el = 32'hFFFFFFFF;
        end else if (o == 2'b10) begin
            if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
                el = 32'h80000000;
                eh = 32'd0;
            end else begin
                el = sx / sy;
                eh = sx % sy;
            end
        end else begin
            el = x / y;
            eh = x % y;
        end
    endfunction

    // Issue one op; report latency, busy cycles and post-start state
    task automatic run_op(
        input  logic [1:0]  o,
        input  logic [31:0] x,
        input  logic [31:0] y,
        input  logic        hwe,
        input  logic        lwe,
        input  logic [31:0] wd,
        output int          lat,
        output int          bcnt,
        output logic [31:0] hi0,
        output logic [31:0] lo0,
        output logic        d0
    );
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        hi_we = hwe; lo_we = lwe; wdata = wd;
        @(posedge clk); #1;
        bcnt = busy ? 1 : 0;
        hi0 = hi; lo0 = lo; d0 = done;
        lat = 0;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        a = $urandom; b = $urandom; op = 2'($urandom);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
            if (busy) bcnt++;
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #10;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_fail++;
            $display("FAIL reset: busy=%b done=%b hi=%h lo=%h want 0 0 0 0",
                     busy, done, hi, lo);
        end
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        logic [1:0]  t_op [8] = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd2, 2'd3, 2'd2, 2'd2};
        logic [31:0] t_a  [8] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd7,
                                  32'd7, 32'd5, 32'h80000000, 32'hFFFFFFF9};
        logic [31:0] t_b  [8] = '{32'hFFFFFFFF, 32'd7, 32'd2, 32'd2,
                                  32'hFFFFFFFE, 32'd0, 32'hFFFFFFFF, 32'd0};
        logic [31:0] t_hi [8] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,
                                  32'd1, 32'd5, 32'd0, 32'hFFFFFFF9};
        logic [31:0] t_lo [8] = '{32'h00000001, 32'hFFFFFFEB, 32'hFFFFFFFD, 32'd3,
                                  32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
        int lat, bcnt;
        logic [31:0] h0, l0;
        logic d0;
        for (int i = 0; i < 8; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], 1'b0, 1'b0, 32'd0, lat, bcnt, h0, l0, d0);
            n_checks++;
            if (lat !== 33 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL dir%0d_latency: lat=%0d busy=%b want 33 0", i, lat, busy);
            end
            n_checks++;
            if (bcnt !== 33) begin
                n_fail++;
                $display("FAIL dir%0d_busy_cycles: got %0d want 33", i, bcnt);
            end
            n_checks++;
            if (hi !== t_hi[i] || lo !== t_lo[i]) begin
                n_fail++;
                $display("FAIL dir%0d_result: hi=%h lo=%h want hi=%h lo=%h",
                         i, hi, lo, t_hi[i], t_lo[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] x, y, eh, el, h0, l0;
        logic d0;
        int lat, bcnt, r;
        for (int i = 0; i < 32; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            y = $urandom;
            r = $urandom_range(0, 7);
            if (r == 0) y = 32'd0;
            if (r == 1) begin x = 32'h80000000; y = 32'hFFFFFFFF; end
            if (r == 2) y = y >> 28;
            if (r == 3) x = 32'h80000000;
            model(o, x, y, eh, el);
            run_op(o, x, y, 1'b0, 1'b0, 32'd0, lat, bcnt, h0, l0, d0);
            n_checks++;
            if (lat !== 33 || hi !== eh || lo !== el) begin
                n_fail++;
                $display("FAIL rand%0d op=%0d a=%h b=%h: lat=%0d hi=%h lo=%h want 33 %h %h",
                         i, o, x, y, lat, hi, lo, eh, el);
            end
        end
    endtask

    task automatic test_mt();
        @(negedge clk);
        hi_we = 1'b1; wdata = 32'h0BADF00D;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h00001234;
        @(posedge clk); #1;
        n_checks++;
        if (lo !== 32'h00001234 || hi !== 32'h0BADF00D) begin
            n_fail++;
            $display("FAIL mtlo: hi=%h lo=%h want 0badf00d 00001234", hi, lo);
        end
        @(negedge clk);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5A5A5;
        @(posedge clk); #1;
        n_checks++;
        if (hi !== 32'hA5A5A5A5 || lo !== 32'hA5A5A5A5 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL mt_both: hi=%h lo=%h busy=%b done=%b want a5a5a5a5 a5a5a5a5 0 0",
                     hi, lo, busy, done);
        end
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
    endtask

    task automatic test_start_with_write();
        int lat, bcnt;
        logic [31:0] h0, l0;
        logic d0;
        @(negedge clk);
        lo_we = 1'b1; wdata = 32'h77777777;
        @(negedge clk);
        lo_we = 1'b0;
        run_op(2'b01, 32'd6, 32'd7, 1'b0, 1'b1, 32'hDEADBEEF, lat, bcnt, h0, l0, d0);
        n_checks++;
        if (l0 !== 32'h77777777 || bcnt !== 33) begin
            n_fail++;
            $display("FAIL start_lo_we_drop: lo=%h busy_cycles=%0d want 77777777 33", l0, bcnt);
        end
        n_checks++;
        if (lat !== 33 || hi !== 32'd0 || lo !== 32'd42) begin
            n_fail++;
            $display("FAIL start_lo_we_result: lat=%0d hi=%h lo=%h want 33 0 2a", lat, hi, lo);
        end
    endtask

    task automatic test_busy_ignore();
        logic [31:0] x, y, eh, el;
        int lat;
        lat = 0;
        @(negedge clk);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h11111111;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        x = $urandom; y = $urandom;
        model(2'b00, x, y, eh, el);
        start = 1'b1; op = 2'b00; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = '0; b = '0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 5) begin
                start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd0;
                hi_we = 1'b1; wdata = 32'hCAFEF00D;
            end
            @(posedge clk); #1;
            if (k == 5) begin
                n_checks++;
                if (hi !== 32'h11111111 || lo !== 32'h11111111 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL busy_ignore_mthi: hi=%h lo=%h busy=%b want 11111111 11111111 1",
                             hi, lo, busy);
                end
            end
            if (done) begin
                lat = k;
                break;
            end
            @(negedge clk);
            start = 1'b0; hi_we = 1'b0;
        end
        n_checks++;
        if (lat !== 33 || hi !== eh || lo !== el) begin
            n_fail++;
            $display("FAIL busy_ignore_result: lat=%0d hi=%h lo=%h want 33 %h %h",
                     lat, hi, lo, eh, el);
        end
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== eh) begin
            n_fail++;
            $display("FAIL busy_ignore_noqueue: busy=%b done=%b hi=%h want 0 0 %h",
                     busy, done, hi, eh);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] eh, el, h0, l0;
        logic d0;
        int lat, bcnt;
        run_op(2'b11, 32'd100, 32'd7, 1'b0, 1'b0, 32'd0, lat, bcnt, h0, l0, d0);
        n_checks++;
        if (lat !== 33 || done !== 1'b1 || hi !== 32'd2 || lo !== 32'd14) begin
            n_fail++;
            $display("FAIL b2b_first: lat=%0d done=%b hi=%h lo=%h want 33 1 2 e", lat, done, hi, lo);
        end
        model(2'b10, 32'hFFFFFF9C, 32'd7, eh, el);
        run_op(2'b10, 32'hFFFFFF9C, 32'd7, 1'b0, 1'b0, 32'd0, lat, bcnt, h0, l0, d0);
        n_checks++;
        if (d0 !== 1'b0 || bcnt !== 33 || h0 !== 32'd2 || l0 !== 32'd14) begin
            n_fail++;
            $display("FAIL b2b_accept: done=%b busy_cycles=%0d hi=%h lo=%h want 0 33 2 e",
                     d0, bcnt, h0, l0);
        end
        n_checks++;
        if (lat !== 33 || hi !== eh || lo !== el) begin
            n_fail++;
            $display("FAIL b2b_second: lat=%0d hi=%h lo=%h want 33 %h %h", lat, hi, lo, eh, el);
        end
    endtask

    task automatic test_reset_mid();
        int lat, bcnt;
        logic [31:0] h0, l0;
        logic d0;
        @(negedge clk);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5A5A5A5A;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        start = 1'b1; op = 2'b01; a = $urandom; b = $urandom;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h want 0 0 0 0",
                     busy, done, hi, lo);
        end
        @(negedge clk) rst = 1'b1;
        run_op(2'b01, 32'd3, 32'd4, 1'b0, 1'b0, 32'd0, lat, bcnt, h0, l0, d0);
        n_checks++;
        if (lat !== 33 || hi !== 32'd0 || lo !== 32'd12) begin
            n_fail++;
            $display("FAIL reset_mid_after: lat=%0d hi=%h lo=%h want 33 0 c", lat, hi, lo);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mt();
        test_start_with_write();
        test_busy_ignore();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu.md
# mdu

Iterative multiply/divide unit for the MIPS core. It consumes the two register-file read operands (rs, rt) for MULT, MULTU, DIV and DIVU, and computes the result over 32 iteration cycles. It holds the 64-bit result in architectural HI/LO registers, which the MFHI/MFLO path reads. MTHI/MTLO write HI/LO directly when the unit is idle.

## Interface
Parameters:
- none; width is fixed at 32 bits.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: launch an operation; sampled only in IDLE.
- `op`, in, 2: operation select; 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`, in, 32: rs operand (register-file read port 1); the dividend or multiplicand.
- `b`, in, 32: rt operand (register-file read port 2); the divisor or multiplier.
- `hi_we`, in, 1: MTHI write enable.
- `lo_we`, in, 1: MTLO write enable.
- `wdata`, in, 32: MTHI/MTLO data.
- `busy`, out, 1: operation in progress.
- `done`, out, 1: one-cycle pulse when HI/LO carry a new result.
- `hi`, out, 32: HI register.
- `lo`, out, 32: LO register.

## Operation
- States:
  - IDLE.
  - RUN: 32 iterations, counted by a 5-bit `cnt`.
  - FIX: sign correction and writeback.
- IDLE with `start=1`:
  - latch `op`.
  - latch |a| and |b| (absolute value for signed ops, raw value for unsigned ops).
  - latch sign(a) and sign(b); `cnt`=0; go to RUN.
- RUN, multiply: shift-add on a 64-bit accumulator, one multiplier bit per cycle, LSB first.
- RUN, divide: restoring division on a 64-bit remainder/quotient pair, one quotient bit per cycle, MSB first.
- RUN: after the `cnt`=31 iteration, go to FIX.
- FIX:
  - Multiply: negate the 64-bit product if sign(a)^sign(b) and op is signed; then HI=product[63:32], LO=product[31:0].
  - Divide: LO=quotient, negated if sign(a)^sign(b) (signed op); HI=remainder, negated if sign(a)=1 (signed op). This is truncating division, so the remainder takes the dividend's sign.
  - Assert `done`; go to IDLE.
- Divide by zero (b=0, DIV or DIVU): HI=a unmodified, LO=32'hFFFFFFFF, regardless of signedness; timing is the same as a normal divide.
- Signed overflow, DIV 32'h80000000 / 32'hFFFFFFFF: LO=32'h80000000, HI=0 (two's-complement wrap).
- Absolute value of 32'h80000000 is taken as the unsigned magnitude 2^31; the arithmetic is 33-bit safe.
- MTHI/MTLO:
  - In IDLE with `start=0`, `hi_we`/`lo_we` write `wdata` into HI/LO at the next edge.
  - Both enables may be set together.
  - Ignored while `busy=1`.
  - If `start=1` and `hi_we`/`lo_we` are both asserted in the same IDLE cycle, `start` wins and the write is dropped.
- `start` while `busy=1` is ignored, with no queueing.
- HI/LO change only at the FIX edge or on an MTHI/MTLO write.

## Timing
- Reset (`rst`=0, asynchronous):
  - state=IDLE; `busy`=0; `done`=0.
  - `hi`=0, `lo`=0; `cnt`=0.
  - Any in-flight operation is abandoned.
- `start` sampled at edge E0: `busy`=1 from after E0.
- Iterations occur at edges E1..E32.
- At edge E33 (FIX): HI/LO are updated, `done`=1, `busy`=0.
- `done` returns to 0 at E34 unless a new op completes.
- Result-visible latency: 33 cycles from the start edge.
- Throughput: one operation per 33 cycles. A new `start` is accepted in the cycle where `done`=1, since the unit is already IDLE.
- `busy` and `done` are registered outputs, never both 1.
- Operands `a`/`b` need only be valid in the start cycle.

## Structure
- Shared package `mips_mdu_pkg` holds:
  - op encodings: `MDU_MULT`, `MDU_MULTU`, `MDU_DIV`, `MDU_DIVU`.
  - state encodings: `S_IDLE`, `S_RUN`, `S_FIX`.
  - constant `MDU_ITER`=32.
  - divide-by-zero LO constant 32'hFFFFFFFF.
- One sub-module is natural: `mdu_core`, holding the 64-bit datapath (accumulator/remainder, one iteration step per cycle, mul/div select). The FSM, operand latching, sign fixup and HI/LO registers stay in `mdu`.

## Test plan
- MULTU a=32'hFFFFFFFF, b=32'hFFFFFFFF -> `done` at start+33; HI=32'hFFFFFFFE, LO=32'h00000001; `busy` high for exactly 33 cycles.
- MULT a=-3 (32'hFFFFFFFD), b=7 -> HI=32'hFFFFFFFF, LO=32'hFFFFFFEB.
- Signed and unsigned divide, 7 by 2:
  - DIV a=-7, b=2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
  - DIVU a=7, b=2 -> LO=3, HI=1.
  - DIV a=7, b=-2 -> LO=32'hFFFFFFFD, HI=1.
- Divide by zero and signed overflow:
  - DIVU a=5, b=0 -> HI=5, LO=32'hFFFFFFFF.
  - DIV a=32'h80000000, b=32'hFFFFFFFF -> LO=32'h80000000, HI=0.
- Handshake and MTHI/MTLO arbitration:
  - `start` plus `hi_we` at cycle 5 of RUN -> both ignored; result unchanged.
  - MTLO `wdata`=32'h1234 in IDLE -> LO=32'h1234 next edge.
  - `start`+`lo_we` together -> op runs, write dropped.
- Reset mid-operation: `rst`=0 at RUN iteration 10 -> `busy`=0, `done`=0, HI=LO=0 immediately. After release, MULTU 3×4 -> LO=12, HI=0 at start+33.
